// File: rtl/slot_play_ctrl.sv
// Game sequencer in front of the slot core: keeps the credit balance, stretches the
// active-low start/stop strobes, waits for the reels to settle and pays out the result.
module slot_play_ctrl #(
  parameter int unsigned CREDIT_W      = 8,
  parameter int unsigned CREDIT_MAX    = 255,
  parameter logic [31:0] HOLD_CYCLES   = 32'd5000002,
  parameter logic [31:0] SETTLE_CYCLES = 32'd300000010,
  parameter logic [7:0]  PAY_PAIR      = 8'd2,
  parameter logic [7:0]  PAY_TRIPLE    = 8'd10,
  parameter logic [7:0]  PAY_SEVENS    = 8'd50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_in,
  input  logic                play,
  input  logic                halt,
  input  logic [3:0]          slot_out0,
  input  logic [3:0]          slot_out1,
  input  logic [3:0]          slot_out2,
  output logic                start_n,
  output logic                stop_n,
  output logic [CREDIT_W-1:0] credits,
  output logic                busy,
  output logic                win,
  output logic [7:0]          win_amount
);

  typedef enum logic [2:0] {IDLE, START_HOLD, SPIN, STOP_HOLD, SETTLE, EVAL} state_t;

  localparam int unsigned        SUM_W    = CREDIT_W + 8;
  localparam logic [SUM_W-1:0]   MAX_WIDE = SUM_W'(CREDIT_MAX);

  state_t              state, state_nxt;
  logic [31:0]         timer, timer_nxt;
  logic                start_n_nxt, stop_n_nxt, win_nxt, busy_nxt;
  logic [7:0]          win_amount_nxt, payout;
  logic                debit, pay_en;
  logic [SUM_W-1:0]    credit_sum;
  logic [CREDIT_W-1:0] credits_nxt;

  // Reel scoring; only consumed while in EVAL.
  always_comb begin
    payout = '0;
    if (slot_out0 == slot_out1 && slot_out1 == slot_out2)
      payout = (slot_out0 == 4'd7) ? PAY_SEVENS : PAY_TRIPLE;
    else if (slot_out0 == slot_out1 || slot_out1 == slot_out2 || slot_out0 == slot_out2)
      payout = PAY_PAIR;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nxt      = state;
    timer_nxt      = timer + 32'd1;
    start_n_nxt    = start_n;
    stop_n_nxt     = stop_n;
    win_nxt        = 1'b0;
    win_amount_nxt = win_amount;
    debit          = 1'b0;
    pay_en         = 1'b0;
    unique case (state)
      IDLE: begin
        timer_nxt = '0;
        if (play && credits != '0) begin
          state_nxt      = START_HOLD;
          debit          = 1'b1;
          start_n_nxt    = 1'b0;
          win_amount_nxt = '0;
        end
      end
      START_HOLD: if (timer == HOLD_CYCLES - 32'd1) begin
        start_n_nxt = 1'b1;
        timer_nxt   = '0;
        state_nxt   = SPIN;
      end
      SPIN: begin
        timer_nxt = '0;
        if (halt) begin
          stop_n_nxt = 1'b0;
          state_nxt  = STOP_HOLD;
        end
      end
      STOP_HOLD: if (timer == HOLD_CYCLES - 32'd1) begin
        stop_n_nxt = 1'b1;
        timer_nxt  = '0;
        state_nxt  = SETTLE;
      end
      SETTLE: if (timer == SETTLE_CYCLES - 32'd1) begin
        timer_nxt = '0;
        state_nxt = EVAL;
      end
      EVAL: begin
        timer_nxt      = '0;
        pay_en         = 1'b1;
        win_amount_nxt = payout;
        win_nxt        = (payout != '0);
        state_nxt      = IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Coin, debit and payout merge into one wide sum so simultaneous events never wrap.
  always_comb begin
    credit_sum  = SUM_W'(credits) + SUM_W'(coin_in) + (pay_en ? SUM_W'(payout) : '0)
                  - SUM_W'(debit);
    credits_nxt = (credit_sum > MAX_WIDE) ? MAX_WIDE[CREDIT_W-1:0] : credit_sum[CREDIT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      start_n    <= 1'b1;
      stop_n     <= 1'b1;
      credits    <= '0;
      busy       <= 1'b0;
      win        <= 1'b0;
      win_amount <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      start_n    <= start_n_nxt;
      stop_n     <= stop_n_nxt;
      credits    <= credits_nxt;
      busy       <= busy_nxt;
      win        <= win_nxt;
      win_amount <= win_amount_nxt;
    end
  end

endmodule

// File: tb/tb_slot_play_ctrl.sv
// Self-checking bench for slot_play_ctrl: directed game scenarios plus randomized rounds
// scored against a credit/payout reference model.
module tb_slot_play_ctrl;

  localparam int H   = 4;
  localparam int S   = 10;
  localparam int MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_in = 1'b0, play = 1'b0, halt = 1'b0;
  logic [3:0] slot_out0 = '0, slot_out1 = '0, slot_out2 = '0;
  logic       start_n, stop_n, busy, win;
  logic [7:0] credits, win_amount;

  int n_checks = 0;
  int n_fail   = 0;
  int ref_credits = 0;

  slot_play_ctrl #(
    .CREDIT_W(8), .CREDIT_MAX(255), .HOLD_CYCLES(32'd4), .SETTLE_CYCLES(32'd10),
    .PAY_PAIR(8'd2), .PAY_TRIPLE(8'd10), .PAY_SEVENS(8'd50)
  ) dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .play(play), .halt(halt),
    .slot_out0(slot_out0), .slot_out1(slot_out1), .slot_out2(slot_out2),
    .start_n(start_n), .stop_n(stop_n), .credits(credits), .busy(busy),
    .win(win), .win_amount(win_amount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  // Payout from the number of matching reel pairs: 3 pairs = triple, 1 pair = pair.
  function automatic int score(input int a, input int b, input int c);
    int pairs;
    pairs = int'(a == b) + int'(b == c) + int'(a == c);
    if (pairs == 3) return (a == 7) ? 50 : 10;
    if (pairs == 1) return 2;
    return 0;
  endfunction

  task automatic coin();
    coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
    ref_credits = sat(ref_credits + 1);
  endtask

  task automatic do_spin(input int r0, input int r1, input int r2, input bit coin_play,
                         input bit coin_eval, input bit exit_halt, input int spin_wait,
                         input bit stray_play);
    int pay;
    slot_out0 = 4'($urandom); slot_out1 = 4'($urandom); slot_out2 = 4'($urandom);
    play = 1'b1; coin_in = coin_play;
    tick();
    play = 1'b0; coin_in = 1'b0;
    if (!coin_play) ref_credits = ref_credits - 1;
    check("debit", int'(credits), ref_credits);
    check("busy_rise", int'(busy), 1);
    check("win_amount_clr", int'(win_amount), 0);
    for (int i = 0; i < H; i++) begin
      check("start_n_low", int'(start_n), 0);
      if (i == H - 1) halt = exit_halt;
      play = stray_play;
      tick();
      halt = 1'b0; play = 1'b0;
    end
    check("start_n_rel", int'(start_n), 1);
    for (int i = 0; i < spin_wait; i++) begin
      check("stop_n_idle", int'(stop_n), 1);
      tick();
    end
    check("spin_credits", int'(credits), ref_credits);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < H; i++) begin
      check("stop_n_low", int'(stop_n), 0);
      tick();
    end
    check("stop_n_rel", int'(stop_n), 1);
    slot_out0 = 4'(r0); slot_out1 = 4'(r1); slot_out2 = 4'(r2);
    for (int i = 0; i < S; i++) begin
      check("settle_nowin", int'(win), 0);
      check("settle_busy", int'(busy), 1);
      tick();
    end
    coin_in = coin_eval;
    tick();
    coin_in = 1'b0;
    pay = score(r0, r1, r2);
    ref_credits = sat(ref_credits + pay + int'(coin_eval));
    check("win", int'(win), int'(pay > 0));
    check("win_amount", int'(win_amount), pay);
    check("payout_credits", int'(credits), ref_credits);
    check("busy_fall", int'(busy), 0);
    tick();
    check("win_pulse_end", int'(win), 0);
    check("win_amount_hold", int'(win_amount), pay);
  endtask

  initial begin
    tick();
    check("rst_start_n", int'(start_n), 1);
    check("rst_stop_n", int'(stop_n), 1);
    check("rst_credits", int'(credits), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_win_amount", int'(win_amount), 0);
    reset = 1'b1;
    tick();

    // Play with an empty balance is ignored.
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    check("nocoin_start_n", int'(start_n), 1);
    check("nocoin_busy", int'(busy), 0);
    check("nocoin_credits", int'(credits), 0);

    // Coins and triple, sevens, no-win.
    repeat (3) coin();
    check("coins", int'(credits), 3);
    do_spin(3, 3, 3, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    check("triple_total", int'(credits), 12);
    do_spin(7, 7, 7, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    do_spin(1, 2, 3, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    // Pair with coin in EVAL, coin with play, halt at START_HOLD exit, stray play.
    do_spin(5, 2, 5, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    do_spin(2, 9, 9, 1'b1, 1'b0, 1'b1, 3, 1'b1);

    // Saturation.
    while (ref_credits < 251) coin();
    check("pre_sat", int'(credits), 251);
    do_spin(7, 7, 7, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    check("sat_total", int'(credits), 255);
    coin();
    check("sat_coin", int'(credits), 255);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) coin();
      if (ref_credits == 0) coin();
      do_spin(int'($urandom_range(6, 8)), int'($urandom_range(6, 8)), int'($urandom_range(6, 8)),
              1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
      if (r % 8 == 0) while (ref_credits > 3) do_spin(1, 2, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end

    // Reset during SETTLE aborts the spin.
    coin();
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (H + 1) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    repeat (H + 3) tick();
    check("pre_abort_busy", int'(busy), 1);
    slot_out0 = 4'd7; slot_out1 = 4'd7; slot_out2 = 4'd7;
    #2 reset = 1'b0;
    #1;
    check("abort_start_n", int'(start_n), 1);
    check("abort_stop_n", int'(stop_n), 1);
    check("abort_credits", int'(credits), 0);
    check("abort_busy", int'(busy), 0);
    tick();
    reset = 1'b1;
    ref_credits = 0;
    for (int i = 0; i < S + 4; i++) begin
      check("abort_nowin", int'(win), 0);
      tick();
    end
    check("abort_win_amount", int'(win_amount), 0);
    check("abort_end_credits", int'(credits), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
